// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder: beat kinds, MIPS opcode and
// function fields, and the FSM state encoding.
package instr_encoder_pkg;

  localparam logic [3:0] KIND_NOP = 4'd0;
  localparam logic [3:0] KIND_ADD = 4'd1;
  localparam logic [3:0] KIND_SUB = 4'd2;
  localparam logic [3:0] KIND_JR  = 4'd3;
  localparam logic [3:0] KIND_SLL = 4'd4;
  localparam logic [3:0] KIND_ORI = 4'd5;
  localparam logic [3:0] KIND_LW  = 4'd6;
  localparam logic [3:0] KIND_SW  = 4'd7;
  localparam logic [3:0] KIND_BEQ = 4'd8;
  localparam logic [3:0] KIND_LUI = 4'd9;
  localparam logic [3:0] KIND_JAL = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_JR  = 6'b001000;
  localparam logic [5:0] FUNC_SLL = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // Kinds above JAL are reserved and must never produce a write.
  function automatic logic is_legal_kind(input logic [3:0] kind);
    return kind <= KIND_JAL;
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field-to-word packer: turns one beat's kind and fields into the
// 32-bit MIPS instruction word, zeroing every field the kind does not use.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] j_address,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    word    = 32'h0000_0000;
    illegal = ~is_legal_kind(kind);
    unique case (kind)
      KIND_NOP: word = 32'h0000_0000;
      KIND_ADD: word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNC_ADD};
      KIND_SUB: word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNC_SUB};
      KIND_JR:  word = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FUNC_JR};
      KIND_SLL: word = {OP_RTYPE, 5'd0, rt, rd, shamt, FUNC_SLL};
      KIND_ORI: word = {OP_ORI, rs, rt, imm};
      KIND_LW:  word = {OP_LW, rs, rt, imm};
      KIND_SW:  word = {OP_SW, rs, rt, imm};
      KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
      KIND_LUI: word = {OP_LUI, 5'd0, rt, imm};
      KIND_JAL: word = {OP_JAL, j_address};
      default:  word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: packs field beats into MIPS words and writes
// them to instruction memory at consecutive addresses. Optional INSTR_ENCODER_CKSUM_EN adds an XOR checksum.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter  int unsigned DEPTH     = 16,
  parameter  logic [31:0] BASE_ADDR = 32'h0000_3000,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    kind,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [15:0]   imm,
  input  logic [25:0]   j_address,
  output logic          wr_en,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          err
`ifdef INSTR_ENCODER_CKSUM_EN
  ,
  output logic [31:0]   cksum
`endif
);

  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_e      state, state_next;
  logic [31:0] word;
  logic        illegal;
  logic        accept;
  logic        legal_accept;
  logic [31:0] next_addr;

  instr_pack u_pack (
    .kind      (kind),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .imm       (imm),
    .j_address (j_address),
    .word      (word),
    .illegal   (illegal)
  );

  // clr suppresses ready so a beat offered alongside clr is never consumed.
  assign in_ready     = (state != ST_FULL) & ~clr;
  assign accept       = in_valid & in_ready;
  assign legal_accept = accept & ~illegal;
  assign full         = (state == ST_FULL);
  assign next_addr    = BASE_ADDR + (32'(count) << 2);

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ST_IDLE;
    end else if (legal_accept) begin
      state_next = (count == LAST) ? ST_FULL : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= 32'h0000_0000;
      wr_data <= 32'h0000_0000;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, regardless of statement order in this block.
      state <= state_next;
      wr_en <= legal_accept;
      if (legal_accept) begin
        wr_addr <= next_addr;
        wr_data <= word;
      end
      // A strobe already in flight still fires on clr; only the count restarts.
      if (clr) begin
        count <= '0;
      end else if (legal_accept) begin
        count <= count + CW'(1);
      end
      if (clr) begin
        err <= 1'b0;
      end else if (accept & illegal) begin
        err <= 1'b1;
      end
    end
  end

`ifdef INSTR_ENCODER_CKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cksum <= 32'h0000_0000;
    end else if (clr) begin
      cksum <= 32'h0000_0000;
    end else if (wr_en) begin
      cksum <= cksum ^ wr_data;
    end
  end
`endif

endmodule
